// File: rtl/uart_pkg.sv
// Shared UART-block definitions: APB arbiter states and sizing limits.
package uart_pkg;

   localparam int ARB_MAX_MASTERS = 8;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2
   } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module uart_rr_picker #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             valid
);

   logic [PTR_W-1:0] idx_s;

   // Scan from the pointer outward; only the first hit is granted
   always_comb begin
      grant = {N{1'b0}};
      valid = 1'b0;
      idx_s = {PTR_W{1'b0}};
      for (int i = 0; i < N; i++) begin
         idx_s = PTR_W'((int'(ptr) + i) % N);
         if (req[idx_s] && !valid) begin
            grant[idx_s] = 1'b1;
            valid        = 1'b1;
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Round-robin APB3 arbiter: N upstream masters share one downstream UART regmap slave,
// with a bounded ACCESS wait that terminates a stuck transfer with an error.
module uart_apb_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                         i_apb_pclk,
   input  logic                                         i_apb_presetn,
   input  logic [NUM_MASTERS-1:0]                       i_m_psel,
   input  logic [NUM_MASTERS-1:0]                       i_m_penable,
   input  logic [NUM_MASTERS-1:0]                       i_m_pwrite,
   input  logic [NUM_MASTERS-1:0][APB_ADDR_WIDTH-1:0]   i_m_paddr,
   input  logic [NUM_MASTERS-1:0][APB_DATA_WIDTH-1:0]   i_m_pwdata,
   output logic [NUM_MASTERS-1:0]                       o_m_pready,
   output logic [NUM_MASTERS-1:0]                       o_m_pslverr,
   output logic [APB_DATA_WIDTH-1:0]                    o_m_prdata,
   output logic                                         o_apb_psel,
   output logic                                         o_apb_penable,
   output logic                                         o_apb_pwrite,
   output logic [APB_ADDR_WIDTH-1:0]                    o_apb_paddr,
   output logic [APB_DATA_WIDTH-1:0]                    o_apb_pwdata,
   input  logic                                         i_apb_pready,
   input  logic                                         i_apb_pslverr,
   input  logic [APB_DATA_WIDTH-1:0]                    i_apb_prdata,
   output logic [NUM_MASTERS-1:0]                       o_grant,
   output logic                                         o_timeout
);

   localparam int               PTR_W    = $clog2(NUM_MASTERS);
   localparam bit               TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam int               CNT_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TO_EN ? TIMEOUT_CYCLES : 0);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);

   arb_state_t                state_r, state_nxt_s;
   logic [PTR_W-1:0]          ptr_r, owner_r, ptr_nxt_s, pick_idx_s;
   logic [NUM_MASTERS-1:0]    grant_r, pick_grant_s;
   logic                      pick_valid_s, done_s, expire_s;
   logic                      psel_r, penable_r, pwrite_r;
   logic [APB_ADDR_WIDTH-1:0] paddr_r;
   logic [APB_DATA_WIDTH-1:0] pwdata_r;
   logic [CNT_W-1:0]          cnt_r;

   uart_rr_picker #(.N(NUM_MASTERS), .PTR_W(PTR_W)) u_picker (
      .req   (i_m_psel),
      .ptr   (ptr_r),
      .grant (pick_grant_s),
      .valid (pick_valid_s)
   );

   // One-hot pick to index, used to mux the winner's request fields
   always_comb begin
      pick_idx_s = {PTR_W{1'b0}};
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_grant_s[i]) begin
            pick_idx_s = PTR_W'(i);
         end else begin
            pick_idx_s = pick_idx_s;
         end
      end
   end

   assign ptr_nxt_s = (owner_r == PTR_LAST) ? {PTR_W{1'b0}} : owner_r + PTR_W'(1);

   // FSM state register
   always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
      if (!i_apb_presetn) begin
         state_r <= ARB_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state; a real pready in the last allowed cycle beats the timeout
   always_comb begin
      state_nxt_s = state_r;
      done_s      = 1'b0;
      expire_s    = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s = ARB_SETUP;
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_SETUP: state_nxt_s = ARB_ACCESS;
         ARB_ACCESS: begin
            if (i_apb_pready) begin
               done_s      = 1'b1;
               state_nxt_s = ARB_IDLE;
            end else if (TO_EN && (cnt_r == CNT_LAST)) begin
               done_s      = 1'b1;
               expire_s    = 1'b1;
               state_nxt_s = ARB_IDLE;
            end else begin
               state_nxt_s = ARB_ACCESS;
            end
         end
         default: state_nxt_s = ARB_IDLE;
      endcase
   end

   // Downstream request registers, grant and round-robin pointer
   always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
      if (!i_apb_presetn) begin
         grant_r   <= {NUM_MASTERS{1'b0}};
         owner_r   <= {PTR_W{1'b0}};
         ptr_r     <= {PTR_W{1'b0}};
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
         pwrite_r  <= 1'b0;
         paddr_r   <= {APB_ADDR_WIDTH{1'b0}};
         pwdata_r  <= {APB_DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ARB_IDLE: begin
               if (pick_valid_s) begin
                  grant_r   <= pick_grant_s;
                  owner_r   <= pick_idx_s;
                  psel_r    <= 1'b1;
                  penable_r <= 1'b0;
                  pwrite_r  <= i_m_pwrite[pick_idx_s];
                  paddr_r   <= i_m_paddr[pick_idx_s];
                  pwdata_r  <= i_m_pwdata[pick_idx_s];
               end
            end
            ARB_SETUP: penable_r <= 1'b1;
            ARB_ACCESS: begin
               if (done_s) begin
                  psel_r    <= 1'b0;
                  penable_r <= 1'b0;
                  grant_r   <= {NUM_MASTERS{1'b0}};
                  ptr_r     <= ptr_nxt_s;
               end
            end
            default: begin
               psel_r    <= 1'b0;
               penable_r <= 1'b0;
               grant_r   <= {NUM_MASTERS{1'b0}};
            end
         endcase
      end
   end

   // Saturating count of ACCESS wait cycles, cleared outside ACCESS
   always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
      if (!i_apb_presetn) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r != ARB_ACCESS) || done_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Completion routed to the owner only; dropped if the owner abandoned psel
   always_comb begin
      o_m_pready  = {NUM_MASTERS{1'b0}};
      o_m_pslverr = {NUM_MASTERS{1'b0}};
      o_m_prdata  = {APB_DATA_WIDTH{1'b0}};
      if (done_s) begin
         o_m_prdata = expire_s ? {APB_DATA_WIDTH{1'b0}} : i_apb_prdata;
         if (i_m_psel[owner_r]) begin
            o_m_pready[owner_r]  = 1'b1;
            o_m_pslverr[owner_r] = expire_s | i_apb_pslverr;
         end else begin
            o_m_pready = {NUM_MASTERS{1'b0}};
         end
      end else begin
         o_m_prdata = {APB_DATA_WIDTH{1'b0}};
      end
   end

   assign o_apb_psel    = psel_r;
   assign o_apb_penable = penable_r;
   assign o_apb_pwrite  = pwrite_r;
   assign o_apb_paddr   = paddr_r;
   assign o_apb_pwdata  = pwdata_r;
   assign o_grant       = grant_r;
   assign o_timeout     = expire_s;

   logic unused_s;
   assign unused_s = ^i_m_penable;

endmodule
